// File: rtl/seq110_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq110_pkg
// Purpose  : Shared types for the "110" lane scheduler: per-lane detector
//            context encoding and scheduler FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package seq110_pkg;

  // Detector context encodings (stored per lane, 2 bits each)
  localparam logic [1:0] CTX_IDLE_ENC  = 2'd0;
  localparam logic [1:0] CTX_GOT1_ENC  = 2'd1;
  localparam logic [1:0] CTX_GOT11_ENC = 2'd2;

  // Scheduler state encodings
  localparam logic [1:0] S_ARB_ENC  = 2'd0;
  localparam logic [1:0] S_RUN_ENC  = 2'd1;
  localparam logic [1:0] S_SAVE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = CTX_IDLE_ENC,
    GOT1  = CTX_GOT1_ENC,
    GOT11 = CTX_GOT11_ENC
  } ctx_t;

  typedef enum logic [1:0] {
    S_ARB  = S_ARB_ENC,
    S_RUN  = S_RUN_ENC,
    S_SAVE = S_SAVE_ENC
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/seq110_step.sv
`default_nettype none
// ============================================================================
// Module   : seq110_step
// Purpose  : Combinational "110" Mealy step function. One instance is shared
//            by all lanes; the caller supplies the lane's saved context.
//            No overlap: after a match the detector restarts from IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module seq110_step
  import seq110_pkg::*;
(
  input  ctx_t ctx_in,
  input  logic din,
  output ctx_t ctx_out,
  output logic match
);

  // Next-context and match decode for one consumed bit
  always_comb begin
    ctx_out = IDLE;
    match   = 1'b0;
    case (ctx_in)
      IDLE:    ctx_out = din ? GOT1 : IDLE;
      GOT1:    ctx_out = din ? GOT11 : IDLE;
      GOT11: begin
        ctx_out = din ? GOT11 : IDLE;
        match   = ~din;
      end
      default: ctx_out = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq110_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seq110_lane_scheduler
// Purpose  : Round-robin time-multiplexing of one "110" detector step across
//            NUM_LANES serial lanes, with per-lane context save/restore.
//            Optional per-lane saturating match counters are built when the
//            macro SEQ110_MATCH_CNT_EN is defined; otherwise match_cnt is 0.
// Revision : 1.0 - initial release
// ============================================================================
module seq110_lane_scheduler
  import seq110_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_LANES-1:0]         req,
  input  logic [NUM_LANES-1:0]         bit_in,
  output logic [NUM_LANES-1:0]         bit_ack,
  output logic [NUM_LANES-1:0]         grant,
  output logic                         det_valid,
  output logic [$clog2(NUM_LANES)-1:0] det_lane,
  output logic [NUM_LANES*CNT_W-1:0]   match_cnt
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int BCNT_W = 8;

  sched_state_t        state, state_nxt;
  logic [LANE_W-1:0]   lane_sel;
  logic [LANE_W-1:0]   last_grant;
  logic [BCNT_W-1:0]   burst_cnt;
  ctx_t                work_ctx;
  ctx_t                ctx_mem [NUM_LANES];
  logic                det_pend;

  logic [NUM_LANES-1:0] lane_onehot;
  logic                 pick_found;
  logic [LANE_W-1:0]    pick_lane;
  logic [LANE_W:0]      cand;
  logic                 fire;
  logic                 burst_last;
  ctx_t                 step_ctx;
  logic                 step_match;

  assign lane_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << lane_sel;
  assign burst_last  = (burst_cnt == BCNT_W'(BURST_LEN - 1));

  // The single shared detector step
  seq110_step u_step (
    .ctx_in  (work_ctx),
    .din     (bit_in[lane_sel]),
    .ctx_out (step_ctx),
    .match   (step_match)
  );

  // Round-robin pick: first requesting lane strictly after last_grant
  always_comb begin
    pick_found = 1'b0;
    pick_lane  = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = {1'b0, last_grant} + (LANE_W+1)'(k);
      if (cand >= (LANE_W+1)'(NUM_LANES)) begin
        cand = cand - (LANE_W+1)'(NUM_LANES);
      end
      if (!pick_found && req[cand[LANE_W-1:0]]) begin
        pick_found = 1'b1;
        pick_lane  = cand[LANE_W-1:0];
      end
    end
  end

  // Scheduler state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus Mealy grant/ack outputs
  always_comb begin
    state_nxt = state;
    grant     = '0;
    bit_ack   = '0;
    fire      = 1'b0;
    case (state)
      S_ARB: begin
        if (enable && pick_found) state_nxt = S_RUN;
      end
      S_RUN: begin
        grant = lane_onehot;
        if (enable) begin
          if (req[lane_sel]) begin
            fire    = 1'b1;
            bit_ack = lane_onehot;
            if (burst_last) state_nxt = S_SAVE;
          end else begin
            // Requester went quiet: end the burst without losing a bit
            state_nxt = S_SAVE;
          end
        end
      end
      S_SAVE: begin
        grant = lane_onehot;
        if (enable) state_nxt = S_ARB;
      end
      default: state_nxt = S_ARB;
    endcase
  end

  // Working context, burst bookkeeping and per-lane context storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_sel   <= '0;
      last_grant <= LANE_W'(NUM_LANES - 1);
      burst_cnt  <= '0;
      work_ctx   <= IDLE;
      for (int i = 0; i < NUM_LANES; i++) ctx_mem[i] <= IDLE;
    end else if (enable) begin
      case (state)
        S_ARB: begin
          if (pick_found) begin
            lane_sel  <= pick_lane;
            work_ctx  <= ctx_mem[pick_lane];
            burst_cnt <= '0;
          end
        end
        S_RUN: begin
          if (fire) begin
            work_ctx  <= step_ctx;
            burst_cnt <= burst_cnt + BCNT_W'(1);
          end
        end
        S_SAVE: begin
          ctx_mem[lane_sel] <= work_ctx;
          last_grant        <= lane_sel;
        end
        default: ;
      endcase
    end
  end

  // Detection pulse register; a pending pulse waits out an enable-low period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_pend <= 1'b0;
      det_lane <= '0;
    end else if (enable) begin
      det_pend <= fire & step_match;
      if (fire && step_match) det_lane <= lane_sel;
    end
  end

  assign det_valid = det_pend & enable;

`ifdef SEQ110_MATCH_CNT_EN
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_match_cnt
    logic [CNT_W-1:0] cnt;
    // Saturating per-lane match counter
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (fire && step_match && (lane_sel == LANE_W'(g)) && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
    assign match_cnt[g*CNT_W +: CNT_W] = cnt;
  end
`else
  assign match_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq110_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq110_lane_scheduler
// Purpose  : Self-checking bench: table-driven single-lane vectors, then
//            stream-driven scenarios checked against a reference model with
//            a detection scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq110_lane_scheduler;

  localparam int NL = 4;
  localparam int BL = 2;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [NL-1:0]   req;
  logic [NL-1:0]   bit_in;
  logic [NL-1:0]   bit_ack;
  logic [NL-1:0]   grant;
  logic            det_valid;
  logic [1:0]      det_lane;
  logic [NL*CW-1:0] match_cnt;

  seq110_lane_scheduler #(.NUM_LANES(NL), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .bit_in(bit_in),
    .bit_ack(bit_ack), .grant(grant), .det_valid(det_valid),
    .det_lane(det_lane), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model state
  int m_ph, m_lane, m_cnt, m_last, m_work;
  int m_ctx [NL];
  int m_mc  [NL];
  int detq [$];

  // Per-lane input streams (bit 0 is presented first)
  logic [63:0] sbits [NL];
  int          slen  [NL];

  // Observation records
  int det_seen [NL];
  int gq [$];
  int rise_cyc [$];
  int burst_acks [$];
  int acks;
  int cyc;
  logic [NL-1:0] prev_grant;

  typedef struct {
    logic          en;
    logic [NL-1:0] rq;
    logic [NL-1:0] bv;
    logic [NL-1:0] ack;
    logic [NL-1:0] gnt;
    logic          det;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int c, input logic b);
    if (c == 0) return b ? 1 : 0;
    if (c == 1) return b ? 2 : 0;
    return b ? 2 : 0;
  endfunction

  function automatic int lane_of(input logic [NL-1:0] v);
    int r = -1;
    for (int i = 0; i < NL; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic busy();
    logic b = (m_ph != 0);
    for (int i = 0; i < NL; i++) if (slen[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic push_stream(input int l, input string s);
    for (int i = 0; i < s.len(); i++) begin
      sbits[l][slen[l]] = (s[i] == 8'h31);
      slen[l]++;
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_lane = 0; m_cnt = 0; m_last = NL - 1; m_work = 0;
    for (int i = 0; i < NL; i++) begin
      m_ctx[i] = 0; m_mc[i] = 0; sbits[i] = '0; slen[i] = 0; det_seen[i] = 0;
    end
    detq.delete(); gq.delete(); rise_cyc.delete(); burst_acks.delete();
    acks = 0; cyc = 0; prev_grant = '0;
  endtask

  // Entered and left at 1 time unit after a rising edge
  task automatic apply_reset();
    reset = 1'b0; enable = 1'b0; req = '0; bit_in = '0;
    #2;
    check("rst_bit_ack", int'(bit_ack), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_det_valid", int'(det_valid), 0);
    check("rst_det_lane", int'(det_lane), 0);
    check("rst_match_cnt", int'(match_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic do_cycle(input logic en);
    logic [NL-1:0] rq, bv, eg, ea;
    logic fire, mt;
    int l;
    for (int i = 0; i < NL; i++) begin
      rq[i] = (slen[i] > 0);
      bv[i] = sbits[i][0];
    end
    enable = en; req = rq; bit_in = bv;
    #2;
    eg   = (m_ph != 0) ? (NL'(1) << m_lane) : '0;
    fire = en && (m_ph == 1) && rq[m_lane];
    ea   = fire ? eg : '0;
    check("grant", int'(grant), int'(eg));
    check("bit_ack", int'(bit_ack), int'(ea));
    if (en && detq.size() > 0) begin
      l = detq.pop_front();
      check("det_valid", int'(det_valid), 1);
      check("det_lane", int'(det_lane), l);
    end else begin
      check("det_valid", int'(det_valid), 0);
    end
    if (det_valid) det_seen[det_lane]++;
    if (grant != 0 && prev_grant == 0) begin
      gq.push_back(lane_of(grant)); rise_cyc.push_back(cyc); acks = 0;
    end
    if (bit_ack != 0) acks++;
    if (grant == 0 && prev_grant != 0) burst_acks.push_back(acks);
    prev_grant = grant;
    if (en) begin
      case (m_ph)
        0: begin
          for (int k = 1; k <= NL; k++) begin
            l = (m_last + k) % NL;
            if (m_ph == 0 && rq[l]) begin
              m_ph = 1; m_lane = l; m_work = m_ctx[l]; m_cnt = 0;
            end
          end
        end
        1: begin
          if (fire) begin
            mt = (m_work == 2) && !bv[m_lane];
            m_work = nxt(m_work, bv[m_lane]);
            if (mt) begin
              detq.push_back(m_lane);
              if (m_mc[m_lane] < (1 << CW) - 1) m_mc[m_lane]++;
            end
            sbits[m_lane] = sbits[m_lane] >> 1;
            slen[m_lane]--;
            m_cnt++;
            if (m_cnt == BL) m_ph = 2;
          end else begin
            m_ph = 2;
          end
        end
        default: begin
          m_ctx[m_lane] = m_work; m_last = m_lane; m_ph = 0;
        end
      endcase
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin
      do_cycle(1'b1);
      n++;
    end
    check("drain_bound", int'(n < maxc), 1);
    do_cycle(1'b1);
    do_cycle(1'b1);
  endtask

  task automatic check_counters();
    int e;
    for (int i = 0; i < NL; i++) begin
`ifdef SEQ110_MATCH_CNT_EN
      e = m_mc[i];
`else
      e = 0;
`endif
      check("match_cnt", int'(match_cnt[i*CW +: CW]), e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5];
    total = 0; bad = 0;
    reset = 1'b1; enable = 1'b0; req = '0; bit_in = '0;
    // en, req, bit_in, ack, grant, det  (lane 0 sends 1,1 | save | 0)
    tbl[0] = '{1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0};
    tbl[2] = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0};
    tbl[3] = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0};
    tbl[4] = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[5] = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0};
    tbl[6] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    tbl[7] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0};
    tbl[8] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    @(posedge clk); #1;
    apply_reset();

    for (int r = 0; r < 9; r++) begin
      enable = tbl[r].en; req = tbl[r].rq; bit_in = tbl[r].bv;
      #2;
      check("tbl_bit_ack", int'(bit_ack), int'(tbl[r].ack));
      check("tbl_grant", int'(grant), int'(tbl[r].gnt));
      check("tbl_det_valid", int'(det_valid), int'(tbl[r].det));
      if (tbl[r].det) check("tbl_det_lane", int'(det_lane), 0);
      @(posedge clk); #1;
    end

    // Context save across an interleaved burst
    apply_reset();
    push_stream(1, "110");
    push_stream(2, "00");
    drain(60);
    check("ctx_det_lane1", det_seen[1], 1);
    check("ctx_det_lane2", det_seen[2], 0);

    // Round-robin order, burst length and inter-burst gap
    apply_reset();
    for (int i = 0; i < NL; i++) push_stream(i, "101101");
    drain(200);
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_bursts", int'(gq.size() >= 5), 1);
    if (gq.size() >= 5 && burst_acks.size() >= 4) begin
      for (int b = 0; b < 5; b++) check("rr_order", gq[b], exp_order[b]);
      for (int b = 0; b < 4; b++) check("rr_burst_acks", burst_acks[b], BL);
      for (int b = 1; b < 5; b++) check("rr_gap", rise_cyc[b] - rise_cyc[b-1], BL + 2);
    end

    // Enable freeze mid-burst, then resume to complete "110"
    apply_reset();
    push_stream(2, "110");
    do_cycle(1'b1);
    do_cycle(1'b1);
    for (int i = 0; i < 5; i++) do_cycle(1'b0);
    drain(60);
    check("freeze_det_lane2", det_seen[2], 1);

    // Reset mid-burst while lane 3 sits in GOT11
    apply_reset();
    push_stream(3, "111");
    for (int i = 0; i < 6; i++) do_cycle(1'b1);
    check("pre_rst_grant", int'(grant), 8);
    apply_reset();
    push_stream(3, "0");
    push_stream(0, "1");
    drain(60);
    check("rst_first_grant", (gq.size() > 0) ? gq[0] : -1, 0);
    check("rst_no_det_lane3", det_seen[3], 0);

    // Five matches on lane 0 (counter saturates when counters are built)
    apply_reset();
    push_stream(0, "110110110110110");
    drain(200);
    check("cnt_det_lane0", det_seen[0], 5);
    check_counters();

    // Random traffic with random enable gaps
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NL; i++) begin
        if (slen[i] < 4 && $urandom_range(0, 3) == 0) begin
          int n = $urandom_range(1, 6);
          for (int j = 0; j < n; j++) begin
            sbits[i][slen[i]] = ($urandom_range(0, 3) != 0);
            slen[i]++;
          end
        end
      end
      do_cycle($urandom_range(0, 7) != 0);
    end
    drain(300);
    check_counters();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
